// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled RxD in, majority-voted bits, runtime word length, parity,
// one/two stop bits, false-start rejection, framing-error and break detection towards the RHR.
module uart_rx_engine #(
  parameter int MAX_LEN = 9,
  parameter int OVS     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce_16x_i,
  input  logic               rxd_i,
  input  logic [3:0]         len_i,
  input  logic               par_en_i,
  input  logic [1:0]         par_i,
  input  logic               num_stop_i,
  output logic [MAX_LEN-1:0] rd_o,
  output logic               we_rhr_o,
  output logic               par_err_o,
  output logic               frm_err_o,
  output logic               brk_det_o,
  output logic [2:0]         rx_state_o
);
  localparam int TCW = $clog2(OVS);
  localparam int BCW = $clog2(MAX_LEN + 1);
  localparam logic [TCW-1:0] TC_S0  = TCW'(OVS / 2 - 1);
  localparam logic [TCW-1:0] TC_S1  = TCW'(OVS / 2);
  localparam logic [TCW-1:0] TC_DEC = TCW'(OVS / 2 + 1);
  localparam logic [TCW-1:0] TC_END = TCW'(OVS - 1);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  function automatic logic [BCW-1:0] clamp_len(input logic [3:0] len);
    if (len < 4'd5) begin
      return BCW'(5);
    end else if (32'(len) > MAX_LEN) begin
      return BCW'(MAX_LEN);
    end else begin
      return BCW'(len);
    end
  endfunction

  function automatic logic exp_parity(input logic [1:0] mode, input logic [MAX_LEN-1:0] data);
    case (mode)
      2'b00:   return ~(^data);
      2'b01:   return ^data;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  state_t             state_q;
  logic               rxd_meta_q, rxd_s_q;
  logic [TCW-1:0]     tc_q;
  logic [BCW-1:0]     bc_q, len_q;
  logic               par_en_q, nstop_q;
  logic [1:0]         par_q;
  logic [MAX_LEN-1:0] sh_q, rd_q;
  logic               samp0_q, samp1_q, par_bit_q, frm_q;
  logic               we_q, pe_q, fe_q, bd_q;

  logic               maj_bit, at_dec, at_end, par_bad, stop_last, is_brk;
  logic [TCW-1:0]     tc_nx;

  // Two-flop synchroniser for the asynchronous serial line, idle-high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Bit decision, tick wrap and end-of-frame qualifiers.
  always_comb begin
    maj_bit = (samp0_q & samp1_q) | (samp0_q & rxd_s_q) | (samp1_q & rxd_s_q);
    at_dec  = (tc_q == TC_DEC);
    at_end  = (tc_q == TC_END);
    if (at_end) begin
      tc_nx = '0;
    end else begin
      tc_nx = tc_q + TCW'(1);
    end
    par_bad   = par_en_q & (par_bit_q ^ exp_parity(par_q, sh_q));
    stop_last = (bc_q == BCW'(nstop_q));
    is_brk    = ~maj_bit & (bc_q == '0) & ~(|sh_q) & ~(par_en_q & par_bit_q);
  end

  // Frame sequencer: state, counters and status outputs advance only on oversample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      tc_q      <= '0;
      bc_q      <= '0;
      len_q     <= '0;
      par_en_q  <= 1'b0;
      par_q     <= 2'b00;
      nstop_q   <= 1'b0;
      sh_q      <= '0;
      samp0_q   <= 1'b0;
      samp1_q   <= 1'b0;
      par_bit_q <= 1'b0;
      frm_q     <= 1'b0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      bd_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (ce_16x_i) begin
        if (tc_q == TC_S0) samp0_q <= rxd_s_q;
        if (tc_q == TC_S1) samp1_q <= rxd_s_q;
        case (state_q)
          ST_WAIT: begin
            if (!rxd_s_q) begin
              tc_q <= '0;
            end else if (at_end) begin
              tc_q    <= '0;
              state_q <= ST_IDLE;
            end else begin
              tc_q <= tc_nx;
            end
          end
          ST_IDLE: begin
            if (!rxd_s_q) begin
              state_q   <= ST_START;
              tc_q      <= '0;
              bc_q      <= '0;
              sh_q      <= '0;
              frm_q     <= 1'b0;
              par_bit_q <= 1'b0;
              len_q     <= clamp_len(len_i);
              par_en_q  <= par_en_i;
              par_q     <= par_i;
              nstop_q   <= num_stop_i;
            end
          end
          ST_START: begin
            tc_q <= tc_nx;
            if (at_dec && maj_bit) begin
              state_q <= ST_IDLE;
              tc_q    <= '0;
            end else if (at_end) begin
              state_q <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            tc_q <= tc_nx;
            if (at_dec) begin
              sh_q[bc_q] <= maj_bit;
              bc_q       <= bc_q + BCW'(1);
            end
            if (at_end && (bc_q == len_q)) begin
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
              bc_q    <= '0;
            end
          end
          ST_PARITY: begin
            tc_q <= tc_nx;
            if (at_dec) par_bit_q <= maj_bit;
            if (at_end) state_q <= ST_STOP;
          end
          ST_STOP: begin
            tc_q <= tc_nx;
            // Frame ends at the decision point so the next start edge can be caught mid stop bit.
            if (at_dec) begin
              if (is_brk || stop_last) begin
                we_q    <= 1'b1;
                rd_q    <= is_brk ? '0 : sh_q;
                pe_q    <= par_bad;
                fe_q    <= frm_q | ~maj_bit;
                bd_q    <= is_brk;
                tc_q    <= '0;
                state_q <= (frm_q | ~maj_bit) ? ST_ERROR : ST_IDLE;
              end else begin
                frm_q <= frm_q | ~maj_bit;
              end
            end
            if (at_end) bc_q <= bc_q + BCW'(1);
          end
          ST_ERROR: begin
            if (rxd_s_q) begin
              state_q <= ST_WAIT;
              tc_q    <= TCW'(1);
            end
          end
          default: begin
            state_q <= ST_WAIT;
            tc_q    <= '0;
          end
        endcase
      end
    end
  end

  assign rd_o       = rd_q;
  assign we_rhr_o   = we_q;
  assign par_err_o  = pe_q;
  assign frm_err_o  = fe_q;
  assign brk_det_o  = bd_q;
  assign rx_state_o = state_q;
endmodule
